// File: rtl/lane_mod_accumulator_if.sv
// Request/read/clear bus for the lane-packed RMW accumulator.
// The master drives requests; the slave returns read data and busy.
interface lane_mod_accumulator_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            wr_mode;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  clr_start;
    logic                  busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mode,
        output rd_en, rd_addr, clr_start,
        input  rd_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mode,
        input  rd_en, rd_addr, clr_start,
        output rd_data, busy
    );
endinterface

// File: rtl/lane_mod_accumulator.sv
// Lane-packed mod 2^LOG_Q read-modify-write accumulator with zero-fill sweep.
// Optional macro ACC_SUB_EN enables per-lane subtraction on wr_mode=10.
module lane_mod_accumulator #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_W     = 16,
    parameter int LOG_Q      = 16
) (
    input  logic clk,
    input  logic rst,
    lane_mod_accumulator_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / LANE_W;
    localparam logic [LANE_W:0]   ONE_SH = (LANE_W + 1)'(1) << LOG_Q;
    localparam logic [LANE_W-1:0] LMASK  = LANE_W'(ONE_SH - 1'b1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_drain_cnt, w_drain_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
    logic                  w_clr_we;
    logic                  w_busy;
    logic                  w_accept;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  r_s1_vld, r_s2_vld, r_s3_vld;
    logic [ADDR_WIDTH-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
    logic [DATA_WIDTH-1:0] r_s1_data, r_s2_data, r_s2_old, r_s3_res;
    logic                  r_s1_ovr, r_s2_ovr;
    logic                  w_s1_sub;
    logic                  r_s2_sub;
    logic                  w_hit2, w_hit3;
    logic [DATA_WIDTH-1:0] w_old, w_res;

    assign w_busy   = (r_state != S_IDLE);
    assign w_accept = bus.wr_en && !w_busy;

`ifdef ACC_SUB_EN
    logic r_s1_sub;
    always_ff @(posedge clk) begin
        if (rst) r_s1_sub <= 1'b0;
        else     r_s1_sub <= (bus.wr_mode == 2'b10);
    end
    assign w_s1_sub = r_s1_sub;
`else
    assign w_s1_sub = 1'b0;
`endif

    // Youngest in-flight match wins; RAM is read-first against the s3 commit
    assign w_hit2 = r_s2_vld && (r_s2_addr == r_s1_addr);
    assign w_hit3 = r_s3_vld && (r_s3_addr == r_s1_addr);
    assign w_old  = w_hit2 ? w_res :
                    w_hit3 ? r_s3_res : r_mem[r_s1_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_data <= '0;
            r_s1_ovr  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_data <= '0;
            r_s2_old  <= '0;
            r_s2_ovr  <= 1'b0;
            r_s2_sub  <= 1'b0;
            r_s3_vld  <= 1'b0;
            r_s3_addr <= '0;
            r_s3_res  <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_addr <= bus.wr_addr;
            r_s1_data <= bus.wr_data;
            r_s1_ovr  <= (bus.wr_mode == 2'b00);
            r_s2_vld  <= r_s1_vld;
            r_s2_addr <= r_s1_addr;
            r_s2_data <= r_s1_data;
            r_s2_old  <= w_old;
            r_s2_ovr  <= r_s1_ovr;
            r_s2_sub  <= w_s1_sub;
            r_s3_vld  <= r_s2_vld;
            r_s3_addr <= r_s2_addr;
            r_s3_res  <= w_res;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] w_o, w_d, w_r;
        assign w_o = r_s2_old[l*LANE_W +: LANE_W];
        assign w_d = r_s2_data[l*LANE_W +: LANE_W];
`ifdef ACC_SUB_EN
        assign w_r = r_s2_ovr ? w_d :
                     r_s2_sub ? (w_o - w_d) : (w_o + w_d);
`else
        assign w_r = r_s2_ovr ? w_d : (w_o + w_d);
`endif
        assign w_res[l*LANE_W +: LANE_W] = w_r & LMASK;
    end

`ifndef ACC_SUB_EN
    logic w_unused;
    assign w_unused = r_s2_sub;
`endif

    always_ff @(posedge clk) begin
        if (w_clr_we)      r_mem[r_clr_addr] <= '0;
        else if (r_s3_vld) r_mem[r_s3_addr]  <= r_s3_res;
    end

    always_ff @(posedge clk) begin
        if (rst)             r_rd_data <= '0;
        else if (bus.rd_en)  r_rd_data <= r_mem[bus.rd_addr];
    end

    assign bus.rd_data = r_rd_data;
    assign bus.busy    = w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_clr_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_drain_nxt    = r_drain_cnt;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.clr_start) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == 2'd2) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain_cnt + 2'd1;
                end
            end
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == '1) w_state_nxt = S_IDLE;
                else w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule
